bin2bcd_seq: RTL

//  Sequential shift-add-3 (double-dabble) converter from an unsigned sensor reading to four BCD digits.

---
 rtl/disp_pkg.sv | 17 +
 rtl/bcd_add3.sv | 19 +
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants and types for the display datapath.
//   NUM_DIGITS / BCD_W : shape of the decimal display (four 4-bit BCD digits)
//   DISP_MAX           : largest value the display can show; larger inputs saturate
//   state_e            : converter FSM states
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned BCD_TOT_W  = NUM_DIGITS * BCD_W;
  localparam int unsigned DISP_MAX   = 9999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more, so the
// following left shift carries correctly into the next decimal digit.
//   din   in  4  accumulator nibble before correction
//   dout  out 4  corrected nibble
module bcd_add3
  import disp_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_W'(5)) begin
      dout = din + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter from an unsigned reading to four registered BCD digits.
// One conversion per accepted start; takes BIN_W shift cycles, then pulses done.
// Values above 9999 saturate the digits to 9999 and raise ovf.
//   clk     in   1      clock, rising edge
//   rst     in   1      synchronous reset, active-high
//   start   in   1      conversion request, sampled only while idle
//   bin_in  in   BIN_W  value, captured on the accepting edge
//   busy    out  1      conversion in progress
//   done    out  1      one-cycle pulse: digits and ovf just updated
//   ovf     out  1      last captured value exceeded 9999
//   d0..d3  out  4      BCD ones .. thousands digits
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [BCD_W-1:0] d0,
  output logic [BCD_W-1:0] d1,
  output logic [BCD_W-1:0] d2,
  output logic [BCD_W-1:0] d3
);

  localparam int unsigned CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(BIN_W - 1);

  state_e               state_q;
  logic [BIN_W-1:0]     bin_q;
  logic [BCD_TOT_W-1:0] bcd_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_pend_q;
  logic                 done_q;
  logic                 ovf_q;
  logic [BCD_W-1:0]     d0_q, d1_q, d2_q, d3_q;

  logic [BCD_TOT_W-1:0] bcd_adj;
  logic [BCD_TOT_W-1:0] bcd_shift;
  logic [BIN_W-1:0]     bin_shift;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[g*BCD_W +: BCD_W]),
      .dout (bcd_adj[g*BCD_W +: BCD_W])
    );
  end

  // {bcd, bin} shifted left as one register after correction. For inputs above 9999 the
  // top digit can overflow, but those results are replaced by the saturated value.
  always_comb begin
    bcd_shift = {bcd_adj[BCD_TOT_W-2:0], bin_q[BIN_W-1]};
    bin_shift = {bin_q[BIN_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      d0_q       <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      d3_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q      <= bin_in;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (32'(bin_in) > DISP_MAX);
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_shift;
          bin_q <= bin_shift;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CntLast) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            ovf_q   <= ovf_pend_q;
            // All four digits update on the same edge so the scanner never sees a mix.
            if (ovf_pend_q) begin
              d0_q <= BCD_W'(9);
              d1_q <= BCD_W'(9);
              d2_q <= BCD_W'(9);
              d3_q <= BCD_W'(9);
            end else begin
              d0_q <= bcd_shift[0*BCD_W +: BCD_W];
              d1_q <= bcd_shift[1*BCD_W +: BCD_W];
              d2_q <= bcd_shift[2*BCD_W +: BCD_W];
              d3_q <= bcd_shift[3*BCD_W +: BCD_W];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign d0   = d0_q;
  assign d1   = d1_q;
  assign d2   = d2_q;
  assign d3   = d3_q;

endmodule
